// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB full-speed transmit path: FSM states and
// D+/D- line-state encodings.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_DATA    = 3'd1,
    TX_STUFF   = 3'd2,
    TX_EOP_SE0 = 3'd3,
    TX_EOP_J   = 3'd4
  } tx_state_t;

  // {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int STUFF_LEN_DEF = 6;

endpackage

// File: rtl/usb_nrzi_enc.sv
// Registered NRZI encoder and D+/D- line driver: a 0 toggles the line level,
// a 1 holds it; SE0 and J can be forced for end-of-packet and idle.
module usb_nrzi_enc
  import usb_tx_pkg::*;
(
  input  logic gclk,
  input  logic reset,
  input  logic nrz_bit,
  input  logic bit_en,
  input  logic force_se0,
  input  logic force_j,
  input  logic oe,
  output logic tx_dp,
  output logic tx_dm,
  output logic tx_oe
);

  logic nrzi_level;
  logic level_nxt;

  assign level_nxt = nrz_bit ? nrzi_level : ~nrzi_level;

  // line register stage: one bit time after the bit is presented
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      tx_dp      <= LINE_J[1];
      tx_dm      <= LINE_J[0];
      tx_oe      <= 1'b0;
      nrzi_level <= 1'b1;
    end else begin
      tx_oe <= oe;
      if (force_se0) begin
        {tx_dp, tx_dm} <= LINE_SE0;
      end else if (force_j) begin
        // J re-arms the encoder so every packet starts from the idle level
        {tx_dp, tx_dm} <= LINE_J;
        nrzi_level     <= 1'b1;
      end else if (bit_en) begin
        nrzi_level <= level_nxt;
        tx_dp      <= level_nxt;
        tx_dm      <= ~level_nxt;
      end
    end
  end

endmodule

// File: rtl/usb_tx_bit_stuff.sv
// USB full-speed transmit bit stuffer: inserts a 0 after STUFF_LEN ones,
// NRZI-encodes the stream and closes each packet with SE0 x EOP_SE0_BITS then J.
module usb_tx_bit_stuff
  import usb_tx_pkg::*;
#(
  parameter int STUFF_LEN    = STUFF_LEN_DEF,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic gclk,
  input  logic reset,
  input  logic tx_start,
  input  logic stuff_din,
  input  logic din_valid,
  input  logic din_last,
  output logic stuff_ready,
  output logic tx_dp,
  output logic tx_dm,
  output logic tx_oe,
  output logic busy,
  output logic tx_underrun
);

  localparam logic [2:0] STUFF_LIM = 3'(STUFF_LEN);
  localparam logic [1:0] SE0_LAST  = 2'(EOP_SE0_BITS - 1);

  tx_state_t  state, state_nxt;
  logic [2:0] ones_cnt, ones_nxt;
  logic [1:0] se0_cnt, se0_nxt;
  logic       last_pend, last_nxt;
  logic       underrun;
  logic       enc_bit, bit_en, force_se0, force_j, enc_oe;

  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      state       <= TX_IDLE;
      ones_cnt    <= 3'd0;
      se0_cnt     <= 2'd0;
      last_pend   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      ones_cnt    <= ones_nxt;
      se0_cnt     <= se0_nxt;
      last_pend   <= last_nxt;
      tx_underrun <= underrun;
    end
  end

  always_comb begin
    state_nxt   = state;
    ones_nxt    = ones_cnt;
    se0_nxt     = se0_cnt;
    last_nxt    = last_pend;
    underrun    = 1'b0;
    stuff_ready = 1'b0;
    enc_bit     = 1'b0;
    bit_en      = 1'b0;
    force_se0   = 1'b0;
    force_j     = 1'b0;
    unique case (state)
      TX_IDLE: begin
        force_j = 1'b1;
        if (tx_start) begin
          state_nxt = TX_DATA;
          ones_nxt  = 3'd0;
          last_nxt  = 1'b0;
        end
      end
      TX_DATA: begin
        stuff_ready = 1'b1;
        if (din_valid) begin
          bit_en  = 1'b1;
          enc_bit = stuff_din;
          se0_nxt = 2'd0;
          if (stuff_din) begin
            ones_nxt = ones_cnt + 3'd1;
            // the stuffed 0 must precede EOP, so remember din_last
            if (ones_nxt == STUFF_LIM) begin
              state_nxt = TX_STUFF;
              last_nxt  = din_last;
            end else if (din_last) begin
              state_nxt = TX_EOP_SE0;
            end
          end else begin
            ones_nxt = 3'd0;
            if (din_last) state_nxt = TX_EOP_SE0;
          end
        end else begin
          // underrun: the missing bit time becomes the first SE0
          underrun  = 1'b1;
          force_se0 = 1'b1;
          se0_nxt   = 2'd1;
          state_nxt = (SE0_LAST == 2'd0) ? TX_EOP_J : TX_EOP_SE0;
        end
      end
      TX_STUFF: begin
        bit_en    = 1'b1;
        enc_bit   = 1'b0;
        ones_nxt  = 3'd0;
        se0_nxt   = 2'd0;
        state_nxt = last_pend ? TX_EOP_SE0 : TX_DATA;
      end
      TX_EOP_SE0: begin
        force_se0 = 1'b1;
        se0_nxt   = se0_cnt + 2'd1;
        if (se0_cnt == SE0_LAST) state_nxt = TX_EOP_J;
      end
      TX_EOP_J: begin
        force_j   = 1'b1;
        state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  assign enc_oe = (state != TX_IDLE);
  // stays high through the bit time in which the closing J is on the wire
  assign busy   = (state != TX_IDLE) | tx_oe;

  usb_nrzi_enc u_nrzi_enc (
    .gclk      (gclk),
    .reset     (reset),
    .nrz_bit   (enc_bit),
    .bit_en    (bit_en),
    .force_se0 (force_se0),
    .force_j   (force_j),
    .oe        (enc_oe),
    .tx_dp     (tx_dp),
    .tx_dm     (tx_dm),
    .tx_oe     (tx_oe)
  );

endmodule
